// File: rtl/rx_matched_filter_ts.sv
// Receive matched filter: 21-tap symmetric FIR. One pre-adder and one multiplier
// are shared across the 11 unique taps, sequenced by a small FSM.
module rx_matched_filter_ts #(
    parameter int NTAPS = 21,
    parameter int DW    = 18,
    parameter int ACCW  = 41
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sam_en,
    input  logic signed [DW-1:0] x_in,
    output logic signed [DW-1:0] y,
    output logic                 y_valid,
    output logic                 busy,
    output logic                 overrun
);
    localparam int NU   = (NTAPS + 1) / 2;
    localparam int KW   = $clog2(NU + 1);
    localparam int IW   = $clog2(NTAPS);
    localparam int PW   = 2 * DW + 1;
    localparam int YMSB = 2 * DW - 2;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                  state_reg, state_next;
    logic signed [DW-1:0]    x_reg [NTAPS];
    logic signed [ACCW-1:0]  acc_reg;
    logic [KW-1:0]           k_reg;

    logic [IW-1:0]           idx_a, idx_b;
    logic signed [DW-1:0]    tap_a, tap_b, coef_val;
    logic signed [DW:0]      pre_add;
    logic signed [PW-1:0]    product;
    logic signed [ACCW-1:0]  acc_next;
    logic signed [DW-1:0]    y_sat;
    logic                    accept;

    function automatic logic signed [DW-1:0] coef(input logic [KW-1:0] idx);
        case (idx)
            4'd0:    coef = 18'sd242;
            4'd1:    coef = 18'sd566;
            4'd2:    coef = 18'sd459;
            4'd3:    coef = -18'sd632;
            4'd4:    coef = -18'sd2451;
            4'd5:    coef = -18'sd3419;
            4'd6:    coef = -18'sd1270;
            4'd7:    coef = 18'sd5221;
            4'd8:    coef = 18'sd14679;
            4'd9:    coef = 18'sd23244;
            4'd10:   coef = 18'sd26705;
            default: coef = '0;
        endcase
    endfunction

    assign accept = sam_en && (state_reg == IDLE);

    // Pre-add the mirrored tap pair; the centre tap has no partner.
    always_comb begin
        idx_a    = IW'(k_reg);
        idx_b    = IW'(NTAPS - 1) - IW'(k_reg);
        tap_a    = x_reg[idx_a];
        tap_b    = (k_reg == KW'(NU - 1)) ? '0 : x_reg[idx_b];
        pre_add  = {tap_a[DW-1], tap_a} + {tap_b[DW-1], tap_b};
        coef_val = coef(k_reg);
        product  = pre_add * coef_val;
        acc_next = acc_reg + {{(ACCW - PW){product[PW-1]}}, product};
    end

    // Floor to 1s17; clamp if the discarded high bits disagree with the kept sign.
    always_comb begin
        if ((&acc_reg[ACCW-1:YMSB]) || !(|acc_reg[ACCW-1:YMSB]))
            y_sat = acc_reg[YMSB:DW-1];
        else if (acc_reg[ACCW-1])
            y_sat = {1'b1, {(DW-1){1'b0}}};
        else
            y_sat = {1'b0, {(DW-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sam_en) state_next = MAC;
            MAC:     if (k_reg == KW'(NU - 1)) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NTAPS; i++) x_reg[i] <= '0;
            acc_reg <= '0;
            k_reg   <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            y_valid <= (state_reg == OUT);
            if (sam_en && state_reg != IDLE) overrun <= 1'b1;
            case (state_reg)
                IDLE: if (accept) begin
                    x_reg[0] <= x_in;
                    for (int i = 1; i < NTAPS; i++) x_reg[i] <= x_reg[i-1];
                    acc_reg <= '0;
                    k_reg   <= '0;
                end
                MAC: begin
                    acc_reg <= acc_next;
                    k_reg   <= k_reg + 1'b1;
                end
                OUT:     y <= y_sat;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_matched_filter_ts.sv
// Directed bench for rx_matched_filter_ts: reset, impulse table, latency, DC, overrun, reset mid-MAC.
module tb_rx_matched_filter_ts;
    logic               clk = 1'b0;
    logic               reset_n;
    logic               sam_en;
    logic signed [17:0] x_in;
    logic signed [17:0] y;
    logic               y_valid;
    logic               busy;
    logic               overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [17:0] x;
        int                 y;
    } vec_t;

    vec_t imp_tab [22];

    rx_matched_filter_ts dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sam_en  (sam_en),
        .x_in    (x_in),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    // Called just after a falling edge; strobe is taken at the next rising edge (E0).
    task automatic run_sample(input logic signed [17:0] xv, input int exp_y, input bit check_y,
                              input int gap, input string nm);
        int n;
        int bc;
        sam_en = 1'b1;
        x_in   = xv;
        @(negedge clk);
        sam_en = 1'b0;
        x_in   = 18'sd12345;
        n  = 0;
        bc = 0;
        while (!y_valid && n < 30) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, 12);
        chk({nm, "_busy_clks"}, bc, 12);
        if (check_y) chk({nm, "_y"}, int'(y), exp_y);
        if (gap > 0) begin
            @(negedge clk);
            if (check_y) chk({nm, "_yv_width"}, int'(y_valid), 0);
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic run_impulse(input string tag);
        for (int i = 0; i < 22; i++)
            run_sample(imp_tab[i].x, imp_tab[i].y, 1'b1, 3, $sformatf("%s%0d", tag, i));
    endtask

    initial begin
        int bk [11];
        int n;
        bit bad;
        bk = '{241, 565, 458, -632, -2451, -3419, -1270, 5220, 14678, 23243, 26704};
        for (int i = 0; i < 22; i++) begin
            imp_tab[i].x = (i == 0) ? 18'sd131071 : 18'sd0;
            imp_tab[i].y = (i < 11) ? bk[i] : (i < 21) ? bk[20 - i] : 0;
        end

        // Reset held: outputs stay zero while inputs toggle
        reset_n = 1'b0;
        sam_en  = 1'b0;
        x_in    = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("reset_hold%0d", i), int'({y, y_valid, busy, overrun}), 0);
            sam_en = ~sam_en;
            x_in   = 18'($urandom);
        end
        sam_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Impulse response, spacing 16
        run_impulse("imp");
        chk("imp_overrun", int'(overrun), 0);

        // DC: full-scale negative at minimum spacing
        for (int i = 0; i < 24; i++)
            run_sample(-18'sd131072, -99983, i >= 20, 0, $sformatf("dc%0d", i));
        chk("dc_overrun", int'(overrun), 0);

        // Clean reset before the overrun test
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Overrun: second strobe 5 clocks after the first is dropped
        sam_en = 1'b1;
        x_in   = 18'sd131071;
        @(negedge clk);
        sam_en = 1'b0;
        n = 0;
        repeat (4) begin @(negedge clk); n++; end
        sam_en = 1'b1;
        x_in   = 18'sd50000;
        @(negedge clk);
        n++;
        sam_en = 1'b0;
        x_in   = '0;
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_busy", int'(busy), 1);
        while (!y_valid && n < 30) begin @(negedge clk); n++; end
        chk("ovr_latency", n, 12);
        chk("ovr_y", int'(y), 241);
        repeat (3) @(negedge clk);
        run_sample(18'sd0, 565, 1'b1, 3, "ovr_next");
        chk("ovr_sticky", int'(overrun), 1);

        // Reset during MAC at k=5 aborts cleanly
        sam_en = 1'b1;
        x_in   = 18'sd0;
        @(negedge clk);
        sam_en = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_outputs", int'({y, y_valid, busy, overrun}), 0);
        bad = 1'b0;
        repeat (4) begin @(negedge clk); if (y_valid || busy) bad = 1'b1; end
        reset_n = 1'b1;
        repeat (15) begin @(negedge clk); if (y_valid || busy) bad = 1'b1; end
        chk("midrst_no_valid", int'(bad), 0);

        run_impulse("rimp");
        chk("rimp_overrun", int'(overrun), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
